smart_home_ctrl_p: RTL
======================

# smart_home_ctrl_p

Parametrised next-generation smart-home supervisor: debounces door, window and fire sensors, latches the fire alarm until acknowledged, applies hysteresis to heater/cooler control, and drives one-hot actuator outputs plus a 3-bit display code from a prioritised Moore state machine. It sits between the raw sensor inputs and the actuator/display drivers. It supports N_WIN windows and a configurable temperature width.

## Interface
- TEMP_W, 7, temperature width (unsigned)
- N_WIN, 4, number of window sensors (>=1)
- T_LOW, 50, heater turns on when ST < T_LOW
- T_HIGH, 85, cooler turns on when ST > T_HIGH
- HYST, 2, hysteresis band; constraint T_LOW+HYST <= T_HIGH-HYST
- DEB_CYC, 4, debounce length in cycles (>=1)
- clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- SFD  in  1  front-door sensor (raw, synchronous to clk)
- SRD  in  1  rear-door sensor (raw)
- SW  in  N_WIN  window sensors (raw, one per window)
- SFA  in  1  fire-alarm sensor (raw)
- Ack  in  1  alarm acknowledge, single-cycle pulse
- ST  in  TEMP_W  temperature sample, not debounced
- fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler  out  1 each  actuator drives
- win_idx  out  max(1,$clog2(N_WIN))  lowest-index open debounced window, 0 when none
- display  out  3  state code

## Operation
- Debounce: SFD, SRD, SFA, and each SW bit have a counter (width $clog2(DEB_CYC+1)) and a debounced flag. The counter increments while the raw value differs from the flag and clears on match. The flag flips, and its counter clears, on the DEB_CYC-th consecutive differing sample.
- Fire latch: set when the debounced SFA is 1. Cleared only by Ack while the debounced SFA is 0. Ack while SFA is 1 is ignored. Ack and a new SFA rise in the same cycle: set wins.
- Climate flags are updated every cycle.
  - heat_on sets when ST < T_LOW and clears when ST >= T_LOW+HYST.
  - cool_on sets when ST > T_HIGH and clears when ST <= T_HIGH-HYST.
  - Both flags are mutually exclusive by the parameter constraint.
- State (display code) and priority:
  - ALARM=011 (fire latch)
  - FDOOR=001
  - RDOOR=010
  - WIN=100 (any debounced SW)
  - HEATER=101
  - COOLER=110
  - IDLE=000
- Next state is the highest-priority active condition, evaluated every cycle from any state; there are no sticky states except via the fire latch.
- Outputs are pure decodes of registered state: fdoor=FDOOR, rdoor=RDOOR, alarmbuzz=ALARM, winbuzz=WIN, heater=HEATER, cooler=COOLER. Exactly one or zero is high.
- display equals the state code.
- win_idx is registered. It is updated every cycle from the debounced SW flags, independent of state.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE, display=000, all outputs 0, win_idx=0, debounced flags 0, counters 0, fire latch 0, heat_on/cool_on 0.
- Sensor latency: raw change sampled at edges 1..DEB_CYC; the flag updates at edge DEB_CYC; state and outputs update at edge DEB_CYC+1. With default DEB_CYC=4, the output changes 5 edges after the first sample.
- A glitch shorter than DEB_CYC cycles produces no output change.
- Temperature latency: the flag updates at edge 1 and state at edge 2 after ST crosses a threshold.
- Ack latency: the latch clears at the Ack edge; state leaves ALARM on the next edge.
- Reset mid-debounce or mid-alarm discards all history, and the latch clears immediately.
- ST at 0 or at 2^TEMP_W-1 must not overflow the comparisons (compare at TEMP_W+1 bits).

## Test plan
- Reset, then SFD=1 held: outputs stay 0 for 4 edges; fdoor=1 and display=001 after edge 5. SFD pulse of 3 cycles: no change.
- SFA=1 with SFD=1 and ST=30 all held: display=011 and alarmbuzz=1. Drop SFA: remains 011. Ack while SFA still debounced 1: remains 011. Ack after debounce-low: display=001 next edge.
- ST steps 60→49: heater=1 two edges later. ST=51: heater stays 1. ST=52: heater=0.
- ST steps 60→86: cooler=1. ST=84: stays 1. ST=83: cooler=0.
- N_WIN=4, SW=4'b1010 held: winbuzz=1, display=100, win_idx=1. SW=4'b1000: win_idx=3 after debounce.
- Assert Rst_n=0 during ALARM with SFA=0: all outputs 0 asynchronously, and no alarm after release.

Source files
------------

// File: rtl/smart_home_ctrl_p.sv
// smart_home_ctrl_p
//   Smart-home supervisor. It debounces the door, window and fire sensors and
//   latches the fire alarm until it is acknowledged. It also applies
//   hysteresis to heater/cooler demand. A prioritised Moore machine drives
//   one-hot actuator outputs and a 3-bit display code.
//
// Ports
//   clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   SFD, SRD   raw front/rear door sensors
//   SW         raw window sensors, one bit per window
//   SFA        raw fire-alarm sensor
//   Ack        single-cycle alarm acknowledge
//   ST         temperature sample (unsigned, not debounced)
//   fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler
//              actuator drives, at most one high
//   win_idx    lowest-index open (debounced) window, 0 when none
//   display    current state code
module smart_home_ctrl_p #(
  parameter int TEMP_W  = 7,
  parameter int N_WIN   = 4,
  parameter int T_LOW   = 50,
  parameter int T_HIGH  = 85,
  parameter int HYST    = 2,
  parameter int DEB_CYC = 4,
  localparam int IDX_W  = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              SFD,
  input  logic              SRD,
  input  logic [N_WIN-1:0]  SW,
  input  logic              SFA,
  input  logic              Ack,
  input  logic [TEMP_W-1:0] ST,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [IDX_W-1:0]  win_idx,
  output logic [2:0]        display
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FDOOR  = 3'b001;
  localparam logic [2:0] S_RDOOR  = 3'b010;
  localparam logic [2:0] S_ALARM  = 3'b011;
  localparam logic [2:0] S_WIN    = 3'b100;
  localparam logic [2:0] S_HEATER = 3'b101;
  localparam logic [2:0] S_COOLER = 3'b110;

  // All debounced inputs share one vector: windows in the low bits, then
  // front door, rear door and fire sensor.
  localparam int NS     = N_WIN + 3;
  localparam int I_FD   = N_WIN;
  localparam int I_RD   = N_WIN + 1;
  localparam int I_FA   = N_WIN + 2;
  localparam int CW     = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  // Temperatures are compared one bit wider so that the threshold
  // arithmetic can never wrap at the ends of the ST range.
  localparam int XW = TEMP_W + 1;
  localparam logic [XW-1:0] HEAT_ON_TH  = XW'(T_LOW);
  localparam logic [XW-1:0] HEAT_OFF_TH = XW'(T_LOW + HYST);
  localparam logic [XW-1:0] COOL_ON_TH  = XW'(T_HIGH);
  localparam logic [XW-1:0] COOL_OFF_TH = XW'(T_HIGH - HYST);

  logic [NS-1:0]     raw;
  logic [NS-1:0]     db;
  logic [CW-1:0]     cnt [NS];
  logic              fire_latch;
  logic              fire_active;
  logic              heat_on;
  logic              cool_on;
  logic [XW-1:0]     st_x;
  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [IDX_W-1:0]  win_idx_next;

  assign raw  = {SFA, SRD, SFD, SW};
  assign st_x = {1'b0, ST};

  // The debounce counters count consecutive samples in which the raw input
  // disagrees with its debounced flag. Any agreeing sample restarts the count.
  // The flag takes the raw value on the DEB_CYC-th disagreeing sample.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      db <= '0;
      for (int i = 0; i < NS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (raw[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= raw[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // The fire latch holds the alarm after the sensor clears. Ack releases it
  // only once the debounced sensor is low, so a live sensor always wins.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n)          fire_latch <= 1'b0;
    else if (db[I_FA])   fire_latch <= 1'b1;
    else if (Ack)        fire_latch <= 1'b0;
  end

  // Including the live debounced flag lets the alarm state follow the flag
  // with the same one-edge latency as the other sensors.
  assign fire_active = fire_latch | db[I_FA];

  // The heat and cool demand flags use a hysteresis band. The thresholds are
  // apart by at least 2*HYST, so the two flags can never both be set.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      heat_on <= 1'b0;
      cool_on <= 1'b0;
    end else begin
      if (st_x < HEAT_ON_TH)        heat_on <= 1'b1;
      else if (st_x >= HEAT_OFF_TH) heat_on <= 1'b0;
      if (st_x > COOL_ON_TH)        cool_on <= 1'b1;
      else if (st_x <= COOL_OFF_TH) cool_on <= 1'b0;
    end
  end

  // Next state is the highest-priority active condition. It is re-evaluated
  // every cycle from any state. Only the fire latch is sticky.
  always_comb begin
    state_next = S_IDLE;
    if (fire_active)    state_next = S_ALARM;
    else if (db[I_FD])  state_next = S_FDOOR;
    else if (db[I_RD])  state_next = S_RDOOR;
    else if (|db[N_WIN-1:0]) state_next = S_WIN;
    else if (heat_on)   state_next = S_HEATER;
    else if (cool_on)   state_next = S_COOLER;
  end

  // The loop scans the windows from the top down, so the lowest open index
  // is the last one assigned and therefore the one kept.
  always_comb begin
    win_idx_next = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (db[i]) win_idx_next = IDX_W'(i);
    end
  end

  // This block registers the state and the window index. The window index
  // tracks the flags regardless of the current state.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      win_idx <= '0;
    end else begin
      state   <= state_next;
      win_idx <= win_idx_next;
    end
  end

  // The outputs are pure decodes of the registered state.
  assign display   = state;
  assign fdoor     = (state == S_FDOOR);
  assign rdoor     = (state == S_RDOOR);
  assign alarmbuzz = (state == S_ALARM);
  assign winbuzz   = (state == S_WIN);
  assign heater    = (state == S_HEATER);
  assign cooler    = (state == S_COOLER);

endmodule
